// File: rtl/fence_sequencer.sv
// fence_sequencer
//   Holds a FENCE in decode until every store already issued to data memory
//   has been acknowledged, then lets the fence advance for one cycle. It also
//   keeps the outstanding-store count, back-pressures new stores when that
//   count is saturated, and records sticky overflow/underflow errors.
//
// Ports
//   i_clk           single clock, all state updates on the rising edge
//   i_rst           synchronous active-high reset
//   i_fence_ID      a FENCE is in decode
//   i_mem_write_ID  a store is in decode
//   i_store_issue   a store is issued to data memory this cycle
//   i_store_ack     data memory completes one store this cycle
//   i_flush_EX      taken branch/jump flush from execute
//   o_stall_F       hold fetch      (combinational)
//   o_stall_D       hold decode     (combinational)
//   o_flush_E       bubble execute  (combinational)
//   o_fence_busy    sequencer is not IDLE
//   o_outstanding   registered outstanding-store count
//   o_overflow      sticky: issue attempted at maximum count
//   o_underflow     sticky: ack received at zero count
module fence_sequencer #(
  parameter int CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_fence_ID,
  input  logic             i_mem_write_ID,
  input  logic             i_store_issue,
  input  logic             i_store_ack,
  input  logic             i_flush_EX,
  output logic             o_stall_F,
  output logic             o_stall_D,
  output logic             o_flush_E,
  output logic             o_fence_busy,
  output logic [CNT_W-1:0] o_outstanding,
  output logic             o_overflow,
  output logic             o_underflow
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAIN   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             hold_s;
  logic             busy_s;
  logic             cnt_empty_s;
  logic             cnt_full_s;
  logic             fence_wait_s;

  assign cnt_empty_s = (cnt_q == CNT_ZERO);
  assign cnt_full_s  = (cnt_q == CNT_MAX);
  // A fence must wait if anything is still in flight, including a store
  // leaving for memory in this very cycle.
  assign fence_wait_s = i_fence_ID && (!cnt_empty_s || i_store_issue);

  // State, counter and sticky error registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Outstanding-store counter: saturates at both ends and flags the error.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (i_store_issue && !i_store_ack) begin
      if (cnt_full_s) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (i_store_ack && !i_store_issue) begin
      if (cnt_empty_s) begin
        unf_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Next-state logic; a flush from execute aborts any pending fence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (fence_wait_s) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (cnt_empty_s && !i_store_issue) begin
          state_d = S_RELEASE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (i_flush_EX) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // Output logic: hold is zero-latency; reset and flush both force it low.
  always_comb begin
    hold_s = 1'b0;
    busy_s = 1'b0;
    if (i_rst || i_flush_EX) begin
      hold_s = 1'b0;
    end else begin
      case (state_q)
        S_IDLE:    hold_s = fence_wait_s ||
                            (i_mem_write_ID && cnt_full_s && !i_store_ack);
        S_DRAIN:   hold_s = 1'b1;
        S_RELEASE: hold_s = 1'b0;
        default:   hold_s = 1'b0;
      endcase
    end
    if (i_rst) begin
      busy_s = 1'b0;
    end else begin
      busy_s = (state_q != S_IDLE);
    end
  end

  assign o_stall_F     = hold_s;
  assign o_stall_D     = hold_s;
  assign o_flush_E     = hold_s;
  assign o_fence_busy  = busy_s;
  assign o_outstanding = cnt_q;
  assign o_overflow    = ovf_q;
  assign o_underflow   = unf_q;

endmodule

// File: tb/tb_fence_sequencer.sv
module tb_fence_sequencer;

  localparam int CNT_W = 3;
  localparam int MAX   = (1 << CNT_W) - 1;

  logic             i_clk;
  logic             i_rst;
  logic             i_fence_ID;
  logic             i_mem_write_ID;
  logic             i_store_issue;
  logic             i_store_ack;
  logic             i_flush_EX;
  logic             o_stall_F;
  logic             o_stall_D;
  logic             o_flush_E;
  logic             o_fence_busy;
  logic [CNT_W-1:0] o_outstanding;
  logic             o_overflow;
  logic             o_underflow;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a count of stores in flight plus two flags describing
  // whether a fence is waiting for memory or is being let through.
  int m_cnt;
  bit m_waiting;
  bit m_letting;
  bit m_ovf;
  bit m_unf;

  fence_sequencer #(.CNT_W(CNT_W)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_fence_ID     (i_fence_ID),
    .i_mem_write_ID (i_mem_write_ID),
    .i_store_issue  (i_store_issue),
    .i_store_ack    (i_store_ack),
    .i_flush_EX     (i_flush_EX),
    .o_stall_F      (o_stall_F),
    .o_stall_D      (o_stall_D),
    .o_flush_E      (o_flush_E),
    .o_fence_busy   (o_fence_busy),
    .o_outstanding  (o_outstanding),
    .o_overflow     (o_overflow),
    .o_underflow    (o_underflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, compare outputs at the falling edge,
  // then advance the model across the rising edge. exp_hold >= 0 adds a
  // directed check of the hold outputs against a fixed value.
  task automatic step(input string tag, input bit rst, input bit fence,
                      input bit memw, input bit issue, input bit ack,
                      input bit flush, input int exp_hold);
    bit e_hold;
    bit e_busy;
    int nxt;
    i_rst          = rst;
    i_fence_ID     = fence;
    i_mem_write_ID = memw;
    i_store_issue  = issue;
    i_store_ack    = ack;
    i_flush_EX     = flush;
    if (rst || flush)   e_hold = 1'b0;
    else if (m_letting) e_hold = 1'b0;
    else if (m_waiting) e_hold = 1'b1;
    else e_hold = (fence && (m_cnt != 0 || issue)) ||
                  (memw && m_cnt == MAX && !ack);
    e_busy = !rst && (m_waiting || m_letting);
    @(negedge i_clk);
    chk({tag, "_stallF"}, int'(o_stall_F), int'(e_hold));
    chk({tag, "_stallD"}, int'(o_stall_D), int'(e_hold));
    chk({tag, "_flushE"}, int'(o_flush_E), int'(e_hold));
    chk({tag, "_busy"},   int'(o_fence_busy), int'(e_busy));
    chk({tag, "_cnt"},    int'(o_outstanding), m_cnt);
    chk({tag, "_ovf"},    int'(o_overflow), int'(m_ovf));
    chk({tag, "_unf"},    int'(o_underflow), int'(m_unf));
    if (exp_hold >= 0) chk({tag, "_hold"}, int'(o_stall_F), exp_hold);
    @(posedge i_clk);
    if (rst) begin
      m_cnt = 0; m_waiting = 0; m_letting = 0; m_ovf = 0; m_unf = 0;
    end else begin
      nxt = m_cnt + int'(issue) - int'(ack);
      if (nxt > MAX) begin nxt = MAX; m_ovf = 1; end
      if (nxt < 0)   begin nxt = 0;   m_unf = 1; end
      if (flush) begin
        m_waiting = 0; m_letting = 0;
      end else if (m_letting) begin
        m_letting = 0;
      end else if (m_waiting) begin
        if (m_cnt == 0 && !issue) begin m_waiting = 0; m_letting = 1; end
      end else if (fence && (m_cnt != 0 || issue)) begin
        m_waiting = 1;
      end
      m_cnt = nxt;
    end
    #1;
  endtask

  initial begin
    i_rst = 1'b1; i_fence_ID = 1'b0; i_mem_write_ID = 1'b0;
    i_store_issue = 1'b0; i_store_ack = 1'b0; i_flush_EX = 1'b0;
    @(posedge i_clk); #1;
    m_cnt = 0; m_waiting = 0; m_letting = 0; m_ovf = 0; m_unf = 0;

    // Reset forces outputs low whatever the other inputs do.
    step("rst0", 1, 1, 1, 1, 0, 0, 0);
    step("rst1", 1, 1, 1, 1, 1, 0, 0);
    chk("rst_cnt", int'(o_outstanding), 0);

    // Fence with nothing outstanding passes with zero penalty.
    step("pass", 0, 1, 0, 0, 0, 0, 0);
    step("pass1", 0, 0, 0, 0, 0, 0, 0);

    // cnt=2, fence, two acks: hold cycles 0-3, release cycle 4, idle cycle 5.
    step("pre2a", 0, 0, 0, 1, 0, 0, 0);
    step("pre2b", 0, 0, 0, 1, 0, 0, 0);
    step("d_c0", 0, 1, 0, 0, 0, 0, 1);
    step("d_c1", 0, 1, 0, 0, 1, 0, 1);
    step("d_c2", 0, 1, 0, 0, 1, 0, 1);
    step("d_c3", 0, 1, 0, 0, 0, 0, 1);
    step("d_c4", 0, 1, 0, 0, 0, 0, 0);
    chk("d_c5_busy", int'(o_fence_busy), 0);
    step("d_c5", 0, 0, 0, 0, 0, 0, 0);

    // Fence issued together with a store, then a flush aborts the drain.
    step("fl_c0", 0, 1, 0, 1, 0, 0, 1);
    step("fl_c1", 0, 1, 0, 0, 0, 0, 1);
    step("fl_k",  0, 1, 0, 0, 0, 1, 0);
    chk("fl_idle", int'(o_fence_busy), 0);
    step("fl_k1", 0, 0, 0, 0, 1, 0, 0);

    // Saturation: seven issues, store back-pressure, ack relief, overflow.
    step("sat_r", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step("sat_iss", 0, 0, 0, 1, 0, 0, 0);
    chk("sat_cnt7", int'(o_outstanding), 7);
    step("sat_bp",  0, 0, 1, 0, 0, 0, 1);
    step("sat_ack", 0, 0, 1, 0, 1, 0, 0);
    chk("sat_cnt6", int'(o_outstanding), 6);
    step("sat_up",  0, 0, 0, 1, 0, 0, 0);
    step("sat_ovf", 0, 0, 0, 1, 0, 0, 0);
    chk("sat_ovf_flag", int'(o_overflow), 1);
    chk("sat_ovf_cnt",  int'(o_outstanding), 7);
    step("sat_both", 0, 0, 1, 1, 1, 0, 0);

    // Underflow is sticky until reset.
    step("unf_r", 1, 0, 0, 0, 0, 0, 0);
    step("unf_a", 0, 0, 0, 0, 1, 0, 0);
    chk("unf_set", int'(o_underflow), 1);
    for (int i = 0; i < 3; i++) step("unf_hold", 0, 0, 0, 1, 0, 0, 0);
    chk("unf_sticky", int'(o_underflow), 1);
    step("unf_clr", 1, 0, 0, 0, 0, 0, 0);
    chk("unf_cleared", int'(o_underflow), 0);

    // Reset while draining with cnt=3 discards fence and count.
    for (int i = 0; i < 3; i++) step("rd_iss", 0, 0, 0, 1, 0, 0, 0);
    step("rd_f",   0, 1, 0, 0, 0, 0, 1);
    step("rd_rst", 1, 1, 0, 0, 0, 0, 0);
    chk("rd_cnt",  int'(o_outstanding), 0);
    chk("rd_busy", int'(o_fence_busy), 0);
    step("rd_after", 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step("rnd", ($urandom_range(0, 79) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
